muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide execution unit. It responds to the `multiply`/`div`/`unsign` requests the EXE-stage control decode raises for MULT/MULTU/DIV/DIVU.
- Owns the architectural HI/LO registers, iterates one bit per cycle, and stalls the pipeline via `busy` until the result is committed.
- Sits beside the ALU in EXE. `hi`/`lo` feed MFHI/MFLO forwarding.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous reset, active low.
- multiply  in  1  request MULT/MULTU (level, from EXE decode).
- div  in  1  request DIV/DIVU (level, from EXE decode).
- unsign  in  1  1 = unsigned op, 0 = signed; sampled with the request.
- src1  in  WIDTH  rs value (multiplicand / dividend).
- src2  in  WIDTH  rt value (multiplier / divisor).
- flush  in  1  exception/ERET cancel; aborts any op in flight.
- mthi  in  1  write HI from `wdata`.
- mtlo  in  1  write LO from `wdata`.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  pipeline stall request.
- done  out  1  one-cycle pulse: result committed to HI/LO.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - State goes to IDLE; HI=LO=0; counter=0; internal registers=0.
  - Outputs `busy`=0, `done`=0.
  - Applies in any state, mid-operation included; any op in flight is dropped.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, accept:
  - An op is accepted when (multiply|div) & !flush.
  - If multiply and div are both high, multiply wins.
  - At accept, latch |src1|, |src2| (magnitudes if signed, raw bits if unsign=1), the sign flags, and the op type. Clear counter. Go to MUL or DIV.
- busy (combinational):
  - 1 in IDLE when (multiply|div) & !flush.
  - 1 throughout MUL and DIV.
  - 0 in DONE and otherwise.
  - So if the accept cycle is T, busy is high for T..T+32 (33 cycles).
- MUL:
  - Shift-add on the 2*WIDTH partial product, one multiplier bit per cycle, for WIDTH cycles (T+1..T+32).
  - On the final iteration edge: apply sign fix (negate the 64-bit product if signed and signs differ), then HI=product[63:32], LO=product[31:0]. Go to DONE.
- DIV:
  - Restoring division, one quotient bit per cycle, for WIDTH cycles.
  - Sign fix: quotient negated if signed and signs differ; remainder takes the dividend's sign.
  - Commit LO=quotient, HI=remainder on the final edge. Go to DONE.
- Divide by zero:
  - Runs the full WIDTH cycles.
  - Result is LO=0xFFFFFFFF, HI=src1 as latched (raw bits), regardless of unsign.
  - No trap.
- DONE:
  - Lasts one cycle (T+33); done=1, busy=0.
  - multiply/div are ignored here, since the same instruction is still in EXE this cycle.
  - Always go to IDLE next.
- Back-to-back ops: the next op can be accepted in the IDLE cycle after DONE, i.e. the earliest new accept is T+34.
- flush:
  - In MUL/DIV/DONE: next state is IDLE; HI/LO are not written by the op; done is not raised.
  - In IDLE: blocks accept.
  - flush overrides completion on the same edge.
- mthi/mtlo:
  - Write HI/LO at the clk edge only when state is IDLE or DONE and flush=0.
  - Ignored in MUL/DIV; the pipeline is stalled, so this cannot occur legally.
  - mthi and mtlo can both be asserted in the same cycle; each writes its register.
  - A write in the same cycle as an accept is performed. The op's later commit overwrites both registers.
- hi/lo are direct register outputs; new values are visible the cycle after the write edge.
- Width rules: all negation is two's complement at the full width (64-bit product, 32-bit quotient/remainder). |0x80000000| is treated as the unsigned value 0x80000000.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, accept at T -> busy high T..T+32; done at T+33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT src1=0xFFFFFFFD (-3), src2=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; then MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV src1=0xFFFFFFF9 (-7), src2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 0x80000000/3 -> LO=0x2AAAAAAA, HI=2.
- DIVU 0x12345678/0 -> after 33 busy cycles, LO=0xFFFFFFFF, HI=0x12345678; done pulses once.
- Preload HI=0xAAAA0000 via mthi; start MULT 7*9; assert flush on iteration 10 -> IDLE next cycle, done never asserts, HI=0xAAAA0000 and LO unchanged; a new MULTU 2*3 then gives LO=6.
- Assert resetn=0 mid-DIV -> next cycle busy=0, HI=LO=0; hold multiply high through DONE -> only one op executes (exactly one done pulse).

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_unit : iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
// Revision    : 1.0
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             multiply,
   input  logic             div,
   input  logic             unsign,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             flush,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic [WIDTH-1:0]     src1_q, src1_d;
   logic                 neg_res_q, neg_res_d;
   logic                 neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;

   logic                 w_accept;
   logic                 w_last;
   logic                 w_s1_neg, w_s2_neg;
   logic [WIDTH-1:0]     w_mag1, w_mag2;
   logic [WIDTH:0]       w_mul_sum;
   logic [2*WIDTH-1:0]   w_mul_next, w_prod;
   logic [WIDTH:0]       w_div_trial;
   logic [2*WIDTH-1:0]   w_div_next;
   logic [WIDTH-1:0]     w_quo, w_rem;

   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      src1_d    = src1_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      w_accept = (multiply | div) & ~flush;
      busy     = (state_q == S_MUL) || (state_q == S_DIV) ||
                 ((state_q == S_IDLE) && w_accept);
      w_last   = (cnt_q == CNT_W'(WIDTH - 1));

      w_s1_neg = ~unsign & src1[WIDTH-1];
      w_s2_neg = ~unsign & src2[WIDTH-1];
      w_mag1   = w_s1_neg ? (~src1 + WIDTH'(1)) : src1;
      w_mag2   = w_s2_neg ? (~src2 + WIDTH'(1)) : src2;

      // acc holds {partial product high half, remaining multiplier bits}
      w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
      w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};
      w_prod     = neg_res_q ? (~w_mul_next + (2*WIDTH)'(1)) : w_mul_next;

      // acc holds {partial remainder, dividend bits shifting into quotient}
      w_div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
      w_div_next  = w_div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                       : {w_div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      w_quo = w_div_next[WIDTH-1:0];
      w_rem = w_div_next[2*WIDTH-1:WIDTH];
      if (neg_res_q) w_quo = ~w_quo + WIDTH'(1);
      if (neg_rem_q) w_rem = ~w_rem + WIDTH'(1);

      if (((state_q == S_IDLE) || (state_q == S_DONE)) && !flush) begin
         if (mthi) hi_d = wdata;
         if (mtlo) lo_d = wdata;
      end

      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               state_d   = multiply ? S_MUL : S_DIV;
               cnt_d     = '0;
               acc_d     = {{WIDTH{1'b0}}, (multiply ? w_mag2 : w_mag1)};
               opb_d     = multiply ? w_mag1 : w_mag2;
               src1_d    = src1;
               neg_res_d = w_s1_neg ^ w_s2_neg;
               neg_rem_d = w_s1_neg;
            end
         end
         S_MUL: begin
            acc_d = w_mul_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (w_last) begin
               hi_d    = w_prod[2*WIDTH-1:WIDTH];
               lo_d    = w_prod[WIDTH-1:0];
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DIV: begin
            acc_d = w_div_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (w_last) begin
               if (opb_q == '0) begin
                  hi_d = src1_q;
                  lo_d = '1;
               end else begin
                  hi_d = w_rem;
                  lo_d = w_quo;
               end
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A cancel wins over a completion landing on the same edge
      if (flush && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         src1_q    <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         src1_q    <= src1_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_unit : directed + randomized checks against an arithmetic model
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        resetn, multiply, div, unsign, flush, mthi, mtlo;
   logic [31:0] src1, src2, wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   logic        in_rstn = 1'b0, in_mul = 1'b0, in_div = 1'b0, in_uns = 1'b0;
   logic        in_flush = 1'b0, in_mthi = 1'b0, in_mtlo = 1'b0;
   logic [31:0] in_src1 = '0, in_src2 = '0, in_wdata = '0;

   int n_cmp = 0;
   int n_err = 0;

   // model: phase 0 = idle, 1 = op running, 2 = result-committed cycle
   bit          m_valid = 1'b0;
   int          m_phase = 0;
   int          m_cnt   = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [63:0] m_res = '0;
   logic        obs_busy, obs_done;

   muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .resetn(resetn), .multiply(multiply), .div(div), .unsign(unsign),
      .src1(src1), .src2(src2), .flush(flush), .mthi(mthi), .mtlo(mtlo),
      .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // {HI, LO} as the instruction set defines them
   function automatic logic [63:0] ref_op(input bit is_mul, input bit uns,
                                          input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (is_mul) begin
         if (uns) res = {32'b0, a} * {32'b0, b};
         else     res = sa * sb;
      end else if (b == 32'd0) begin
         res = {a, 32'hFFFF_FFFF};
      end else if (uns) begin
         res = {a % b, a / b};
      end else begin
         q   = sa / sb;
         r   = sa % sb;
         res = {r[31:0], q[31:0]};
      end
      return res;
   endfunction

   task automatic model_step();
      if (!resetn) begin
         m_phase = 0; m_cnt = 0; m_hi = '0; m_lo = '0; m_valid = 1'b1;
      end else begin
         case (m_phase)
            0: begin
               if (!flush) begin
                  if (mthi) m_hi = wdata;
                  if (mtlo) m_lo = wdata;
               end
               if ((multiply || div) && !flush) begin
                  m_res   = ref_op(multiply, unsign, src1, src2);
                  m_cnt   = 32;
                  m_phase = 1;
               end
            end
            1: begin
               if (flush) m_phase = 0;
               else begin
                  m_cnt--;
                  if (m_cnt == 0) begin
                     {m_hi, m_lo} = m_res;
                     m_phase = 2;
                  end
               end
            end
            default: begin
               if (!flush) begin
                  if (mthi) m_hi = wdata;
                  if (mtlo) m_lo = wdata;
               end
               m_phase = 0;
            end
         endcase
      end
   endtask

   task automatic tick();
      logic exp_busy;
      @(negedge clk);
      resetn = in_rstn; multiply = in_mul; div = in_div; unsign = in_uns;
      src1 = in_src1; src2 = in_src2; flush = in_flush;
      mthi = in_mthi; mtlo = in_mtlo; wdata = in_wdata;
      #1;
      exp_busy = (m_phase == 1) || ((m_phase == 0) && (multiply || div) && !flush);
      if (m_valid) begin
         chk("busy", busy, exp_busy);
         chk("done", done, m_phase == 2);
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
      end
      obs_busy = busy;
      obs_done = done;
      @(posedge clk);
      model_step();
   endtask

   // Request held through DONE, as the pipeline does; flush_at<0 means no cancel
   task automatic do_op(input bit m, input bit d, input bit u, input logic [31:0] a,
                        input logic [31:0] b, input int flush_at, input bit rnd_mt);
      int nbusy, ndone;
      nbusy = 0; ndone = 0;
      in_mul = m; in_div = d; in_uns = u; in_src1 = a; in_src2 = b;
      for (int i = 0; i < 40; i++) begin
         in_flush = (i == flush_at);
         if (in_flush && i != 0) begin in_mul = 1'b0; in_div = 1'b0; end
         if (rnd_mt) begin
            in_mthi  = ($urandom_range(0, 7) == 0);
            in_mtlo  = ($urandom_range(0, 7) == 0);
            in_wdata = $urandom;
         end
         tick();
         nbusy += int'(obs_busy);
         ndone += int'(obs_done);
         if (obs_done || i == flush_at) break;
      end
      in_mul = 1'b0; in_div = 1'b0; in_flush = 1'b0; in_mthi = 1'b0; in_mtlo = 1'b0;
      tick();
      if (flush_at < 0 || flush_at >= 33) begin
         chk("done_pulses", ndone, 1);
         if (flush_at < 0) chk("busy_cycles", nbusy, 33);
      end else begin
         chk("done_pulses_flushed", ndone, 0);
         if (flush_at == 0) chk("busy_blocked", nbusy, 0);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int kind, fa;

      chk("ref_multu", ref_op(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
      chk("ref_mult",  ref_op(1, 0, 32'hFFFF_FFFD, 32'd5),         64'hFFFF_FFFF_FFFF_FFF1);
      chk("ref_div",   ref_op(0, 0, 32'hFFFF_FFF9, 32'd2),         64'hFFFF_FFFF_FFFF_FFFD);
      chk("ref_divz",  ref_op(0, 0, 32'h1234_5678, 32'd0),         64'h1234_5678_FFFF_FFFF);

      in_rstn = 1'b0;
      tick(); tick();
      chk("rst_hi", hi, 32'h0);
      chk("rst_busy", busy, 1'b0);
      in_rstn = 1'b1;
      tick();

      do_op(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
      chk("multu_hi", hi, 32'hFFFF_FFFE);
      chk("multu_lo", lo, 32'h0000_0001);
      do_op(1, 0, 0, 32'hFFFF_FFFD, 32'd5, -1, 1'b0);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFF1);
      do_op(1, 1, 0, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);
      chk("mult_min_hi", hi, 32'h4000_0000);
      chk("mult_min_lo", lo, 32'h0);
      do_op(0, 1, 0, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      do_op(0, 1, 1, 32'h8000_0000, 32'd3, -1, 1'b0);
      chk("divu_lo", lo, 32'h2AAA_AAAA);
      chk("divu_hi", hi, 32'h2);
      do_op(0, 1, 1, 32'h1234_5678, 32'd0, -1, 1'b0);
      chk("divz_lo", lo, 32'hFFFF_FFFF);
      chk("divz_hi", hi, 32'h1234_5678);

      in_mthi = 1'b1; in_mtlo = 1'b1; in_wdata = 32'hAAAA_0000;
      tick();
      in_mthi = 1'b0; in_mtlo = 1'b1; in_wdata = 32'h5555_AAAA;
      tick();
      in_mtlo = 1'b0;
      do_op(1, 0, 0, 32'd7, 32'd9, 10, 1'b0);
      chk("flush_hi", hi, 32'hAAAA_0000);
      chk("flush_lo", lo, 32'h5555_AAAA);
      do_op(1, 0, 1, 32'd2, 32'd3, -1, 1'b0);
      chk("after_flush_lo", lo, 32'd6);
      chk("after_flush_hi", hi, 32'd0);

      in_div = 1'b1; in_uns = 1'b0; in_src1 = 32'd1000; in_src2 = 32'd7;
      for (int i = 0; i < 12; i++) tick();
      in_div = 1'b0; in_rstn = 1'b0;
      tick();
      in_rstn = 1'b1;
      tick();
      chk("midrst_busy", obs_busy, 1'b0);
      chk("midrst_hi", hi, 32'h0);
      chk("midrst_lo", lo, 32'h0);

      for (int n = 0; n < 45; n++) begin
         for (int k = $urandom_range(0, 2); k > 0; k--) begin
            in_mthi = $urandom_range(0, 1); in_mtlo = $urandom_range(0, 1);
            in_wdata = $urandom;
            in_flush = ($urandom_range(0, 3) == 0);
            tick();
         end
         in_mthi = 1'b0; in_mtlo = 1'b0; in_flush = 1'b0;
         kind = $urandom_range(0, 3);
         fa   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 34)) : -1;
         do_op(kind != 1, kind == 1 || kind == 2, 1'($urandom_range(0, 1)),
               pick(), pick(), fa, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
